// File: rtl/conditional_branch_unit_if.sv
// Bus bundle for conditional_branch_unit: decision inputs from the
// decoder/ALU side and the PC/status outputs toward instruction fetch.
// master = the datapath driving the unit, slave = the unit itself.
interface conditional_branch_unit_if #(
   parameter int unsigned PC_W = 8
);
   logic            en;
   logic            br_valid;
   logic [2:0]      condition;
   logic [7:0]      value;
   logic [PC_W-1:0] target;
   logic            halt_req;
   logic            resume;
   logic [PC_W-1:0] pc;
   logic            taken;
   logic            halted;
   logic [15:0]     taken_cnt;

   modport master (
      output en, br_valid, condition, value, target, halt_req, resume,
      input  pc, taken, halted, taken_cnt
   );

   modport slave (
      input  en, br_valid, condition, value, target, halt_req, resume,
      output pc, taken, halted, taken_cnt
   );
endinterface

// File: rtl/conditional_branch_unit.sv
// conditional_branch_unit: PC sequencer choosing each cycle between a
// conditional jump to bus.target and a sequential PC+STEP step, with a
// RUN/HALTED state machine and a registered branch-taken flag.
// Optional macro CONDITIONAL_BRANCH_STATS_EN builds a saturating 16-bit
// taken-branch counter; without it taken_cnt is tied to zero.
module conditional_branch_unit #(
   parameter int unsigned PC_W = 8,
   parameter int unsigned STEP = 4
) (
   input logic                    clk,
   input logic                    rst,
   conditional_branch_unit_if.slave bus
);

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   state_t          state_q;
   logic [PC_W-1:0] pc_q;
   logic            taken_q;
   logic            halted_q;

   logic            cond_true;
   logic            br_hit;
   logic [PC_W-1:0] pc_seq;
   logic            val_neg;
   logic            val_zero;

   // Decode the condition code against the signed operand.
   always_comb begin
      val_neg  = bus.value[7];
      val_zero = (bus.value == '0);
      cond_true = 1'b0;
      case (bus.condition)
         3'b000: cond_true = 1'b0;
         3'b001: cond_true = val_zero;
         3'b010: cond_true = val_neg;
         3'b011: cond_true = val_neg | val_zero;
         3'b100: cond_true = 1'b1;
         3'b101: cond_true = ~val_zero;
         3'b110: cond_true = ~val_neg;
         3'b111: cond_true = ~val_neg & ~val_zero;
         default: cond_true = 1'b0;
      endcase
      br_hit = bus.br_valid & cond_true;
      pc_seq = pc_q + PC_W'(STEP);
   end

   // Sequencer FSM: PC update, taken flag and halt/resume handling.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_RUN;
         pc_q     <= '0;
         taken_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (bus.en) begin
                  pc_q    <= br_hit ? bus.target : pc_seq;
                  taken_q <= br_hit;
                  // The PC decision of this cycle still commits when halting.
                  if (bus.halt_req) begin
                     state_q  <= ST_HALTED;
                     halted_q <= 1'b1;
                  end
               end else begin
                  taken_q <= 1'b0;
               end
            end
            ST_HALTED: begin
               taken_q <= 1'b0;
               if (bus.resume) begin
                  state_q  <= ST_RUN;
                  halted_q <= 1'b0;
               end
            end
            default: begin
               state_q  <= ST_RUN;
               taken_q  <= 1'b0;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pc     = pc_q;
   assign bus.taken  = taken_q;
   assign bus.halted = halted_q;

`ifdef CONDITIONAL_BRANCH_STATS_EN
   logic [15:0] cnt_q;
   logic [15:0] cnt_d;
   logic        cnt_inc;

   // Next count: bump on a committed taken branch, stick at all-ones.
   always_comb begin
      cnt_inc = (state_q == ST_RUN) & bus.en & br_hit;
      cnt_d   = cnt_q;
      if (cnt_inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   // Counter register, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bus.taken_cnt = cnt_q;
`else
   assign bus.taken_cnt = '0;
`endif

endmodule

// File: tb/tb_conditional_branch_unit.sv
// Self-checking bench for conditional_branch_unit: directed test-plan
// sequences plus randomized traffic, all compared against a behavioural
// model of the sequencer kept in this file.
module tb_conditional_branch_unit;

   localparam int unsigned PC_W = 8;
   localparam int unsigned STEP = 4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   conditional_branch_unit_if #(.PC_W(PC_W)) cbu_if ();

   conditional_branch_unit #(
      .PC_W (PC_W),
      .STEP (STEP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (cbu_if)
   );

   int n_pass  = 0;
   int n_total = 0;

   // Reference model state
   int unsigned m_pc;
   bit          m_taken;
   bit          m_halted;
   int unsigned m_cnt;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic bit cond_holds(input logic [2:0] c, input logic [7:0] v);
      int sv;
      sv = $signed(v);
      case (c)
         3'd0: return 1'b0;
         3'd1: return sv == 0;
         3'd2: return sv < 0;
         3'd3: return sv <= 0;
         3'd4: return 1'b1;
         3'd5: return sv != 0;
         3'd6: return sv >= 0;
         default: return sv > 0;
      endcase
   endfunction

   // Advance the model by one clock edge using the currently applied inputs.
   task automatic model_edge();
      bit hit;
      if (rst) begin
         m_pc = 0; m_taken = 0; m_halted = 0; m_cnt = 0;
      end else if (m_halted) begin
         m_taken = 0;
         if (cbu_if.resume) m_halted = 0;
      end else if (cbu_if.en) begin
         hit = cbu_if.br_valid && cond_holds(cbu_if.condition, cbu_if.value);
         m_pc = hit ? int'(cbu_if.target) : (m_pc + STEP) % (1 << PC_W);
         m_taken = hit;
`ifdef CONDITIONAL_BRANCH_STATS_EN
         if (hit && m_cnt < 65535) m_cnt++;
`endif
         if (cbu_if.halt_req) m_halted = 1;
      end else begin
         m_taken = 0;
      end
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_eq({tag, ".pc"},     32'(cbu_if.pc),        32'(m_pc));
      check_eq({tag, ".taken"},  32'(cbu_if.taken),     32'(m_taken));
      check_eq({tag, ".halted"}, 32'(cbu_if.halted),    32'(m_halted));
      check_eq({tag, ".cnt"},    32'(cbu_if.taken_cnt), m_cnt);
   endtask

   task automatic set_in(input logic en, input logic br, input logic [2:0] c,
                         input logic [7:0] v, input logic [7:0] tgt,
                         input logic hr, input logic res);
      cbu_if.en = en; cbu_if.br_valid = br; cbu_if.condition = c;
      cbu_if.value = v; cbu_if.target = tgt; cbu_if.halt_req = hr; cbu_if.resume = res;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_in(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
      tick("rst");
      tick("rst");
      rst = 1'b0;
   endtask

   logic [7:0] sweep_val [4] = '{8'h00, 8'h01, 8'h80, 8'h7F};
   // Expected taken per code; bit i corresponds to sweep_val[i].
   logic [3:0] sweep_exp [8] = '{4'b0000, 4'b0001, 4'b0100, 4'b0101,
                                 4'b1111, 4'b1110, 4'b1011, 4'b1010};
   logic [7:0] rnd_val [5] = '{8'h00, 8'h01, 8'h80, 8'h7F, 8'hFF};

   initial begin
      logic [3:0] row;
      logic [7:0] exp_pc;
      logic [7:0] v;

      rst = 1'b1;
      set_in(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);

      // Reset and sequential stepping
      do_reset();
      check_eq("reset.pc",     32'(cbu_if.pc),        32'h0);
      check_eq("reset.taken",  32'(cbu_if.taken),     32'h0);
      check_eq("reset.halted", 32'(cbu_if.halted),    32'h0);
      check_eq("reset.cnt",    32'(cbu_if.taken_cnt), 32'h0);
      set_in(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         tick("seq");
         check_eq("seq.pc", 32'(cbu_if.pc), 32'(i * 4));
      end

      // Condition sweep from pc=8 to target 0x40
      for (int c = 0; c < 8; c++) begin
         row = sweep_exp[c];
         for (int vi = 0; vi < 4; vi++) begin
            do_reset();
            set_in(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
            tick("sw.pre");
            tick("sw.pre");
            set_in(1'b1, 1'b1, 3'(c), sweep_val[vi], 8'h40, 1'b0, 1'b0);
            tick("sw");
            exp_pc = row[vi] ? 8'h40 : 8'h0C;
            check_eq($sformatf("sweep.c%0d.v%0d.pc", c, vi), 32'(cbu_if.pc), 32'(exp_pc));
            check_eq($sformatf("sweep.c%0d.v%0d.taken", c, vi), 32'(cbu_if.taken), 32'(row[vi]));
         end
      end

      // Branch to pc+STEP still counts as taken
      do_reset();
      set_in(1'b1, 1'b1, 3'd4, 8'h00, 8'h04, 1'b0, 1'b0);
      tick("nextpc");
      check_eq("nextpc.pc",    32'(cbu_if.pc),    32'h04);
      check_eq("nextpc.taken", 32'(cbu_if.taken), 32'h1);

      // Wrap-around
      set_in(1'b1, 1'b1, 3'd4, 8'h00, 8'hFC, 1'b0, 1'b0);
      tick("wrap.pre");
      set_in(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
      tick("wrap");
      check_eq("wrap.pc",    32'(cbu_if.pc),    32'h00);
      check_eq("wrap.taken", 32'(cbu_if.taken), 32'h0);

      // Halt / resume
      set_in(1'b1, 1'b1, 3'd4, 8'h00, 8'h10, 1'b0, 1'b0);
      tick("halt.pre");
      set_in(1'b1, 1'b1, 3'd4, 8'h00, 8'h80, 1'b1, 1'b0);
      tick("halt");
      check_eq("halt.pc",     32'(cbu_if.pc),     32'h80);
      check_eq("halt.taken",  32'(cbu_if.taken),  32'h1);
      check_eq("halt.halted", 32'(cbu_if.halted), 32'h1);
      set_in(1'b1, 1'b1, 3'd4, 8'h00, 8'h20, 1'b0, 1'b0);
      repeat (5) begin
         tick("held");
         check_eq("held.pc",    32'(cbu_if.pc),    32'h80);
         check_eq("held.taken", 32'(cbu_if.taken), 32'h0);
      end
      set_in(1'b1, 1'b1, 3'd4, 8'h00, 8'h20, 1'b1, 1'b1);
      tick("resume");
      check_eq("resume.halted", 32'(cbu_if.halted), 32'h0);
      check_eq("resume.pc",     32'(cbu_if.pc),     32'h80);
      set_in(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
      tick("post");
      check_eq("post.pc", 32'(cbu_if.pc), 32'h84);

      // en gating
      set_in(1'b0, 1'b1, 3'd4, 8'h00, 8'h30, 1'b1, 1'b0);
      repeat (3) begin
         tick("frz");
         check_eq("frz.pc", 32'(cbu_if.pc), 32'h84);
      end

      // Reset while halted
      set_in(1'b1, 1'b1, 3'd4, 8'h00, 8'h80, 1'b1, 1'b0);
      tick("halt2");
      check_eq("halt2.halted", 32'(cbu_if.halted), 32'h1);
      rst = 1'b1;
      set_in(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
      tick("midrst");
      rst = 1'b0;
      check_eq("midrst.pc",     32'(cbu_if.pc),        32'h0);
      check_eq("midrst.halted", 32'(cbu_if.halted),    32'h0);
      check_eq("midrst.cnt",    32'(cbu_if.taken_cnt), 32'h0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 49) == 0);
         v = ($urandom_range(0, 1) == 0) ? rnd_val[$urandom_range(0, 4)] : 8'($urandom);
         set_in($urandom_range(0, 7) != 0, 1'($urandom), 3'($urandom), v, 8'($urandom),
                $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
         tick("rnd");
      end
      rst = 1'b0;

      // Statistics: 5 taken, 3 not taken
      do_reset();
      for (int i = 0; i < 8; i++) begin
         set_in(1'b1, 1'b1, (i < 5) ? 3'd4 : 3'd0, 8'h00, 8'h20, 1'b0, 1'b0);
         tick("stat");
      end
`ifdef CONDITIONAL_BRANCH_STATS_EN
      check_eq("stat.cnt5", 32'(cbu_if.taken_cnt), 32'd5);
      set_in(1'b1, 1'b1, 3'd4, 8'h00, 8'h20, 1'b0, 1'b0);
      repeat (65540) tick("sat");
      check_eq("stat.sat", 32'(cbu_if.taken_cnt), 32'hFFFF);
`else
      check_eq("stat.off", 32'(cbu_if.taken_cnt), 32'h0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/conditional_branch_unit.md
Name: conditional_branch_unit

Overview:
- Program-counter sequencer that consumes the 3-bit condition code and the 8-bit signed value defined by the team's conditional-check convention.
- Each cycle it decides between jumping to a target and incrementing the PC.
- Sits at the fetch end of the TC-Bench CPU datapath. It drives the instruction-memory address, and the ALU/decoder feed it condition, value and target.
- Also provides a halt/resume state machine and branch-taken status.

Parameters:
- PC_W, 8, program counter width in bits.
- STEP, 4, PC increment per non-taken or sequential step (bytes per instruction).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- en  input  1  advance enable; 0 freezes all state except reset
- br_valid  input  1  current instruction is a conditional branch
- condition  input  3  condition code, decoded below
- value  input  8  operand, two's complement
- target  input  PC_W  branch destination
- halt_req  input  1  request to stop sequencing
- resume  input  1  leave HALTED
- pc  output  PC_W  current program counter
- taken  output  1  registered; 1 for the cycle after a branch was taken
- halted  output  1  1 while in HALTED
- taken_cnt  output  16  branch-taken statistics (see Optional Feature)

Behaviour:
- Condition decode (combinational, internal; value is signed):
  - 000 never; 001 value==0; 010 value<0; 011 value<=0
  - 100 always; 101 value!=0; 110 value>=0; 111 value>0
  - Sign is bit 7; zero means all bits 0.
- Reset (rst=1 at a clk edge, overrides everything, including mid-halt):
  - pc=0, taken=0, halted=0, taken_cnt=0, state=RUN.
- States: RUN, HALTED.
- RUN with en=1:
  - br_valid=1 and condition true: pc<=target, taken<=1.
  - Otherwise: pc<=pc+STEP modulo 2^PC_W (wraps, no flag), taken<=0.
  - halt_req=1: the PC update above still commits in the same cycle; next state=HALTED, halted<=1.
- RUN with en=0: pc, state and taken_cnt hold; taken<=0.
- HALTED:
  - pc holds; taken<=0; br_valid, halt_req and en are ignored.
  - resume=1 at an edge: state<=RUN, halted<=0. pc is unchanged on that edge; sequencing resumes on the following edge.
  - resume and halt_req both 1 while HALTED: resume wins.
  - resume=1 while in RUN: ignored.
- Latency:
  - Decision inputs are sampled at edge N; pc reflects the result after edge N (one cycle).
  - taken is asserted the same cycle pc shows the target.
- Branch to target==pc+STEP with the condition true: taken=1 (it is a taken branch even though pc is identical).
- No X on outputs after the first reset edge.

Optional Feature:
- Macro: CONDITIONAL_BRANCH_STATS_EN.
- Defined:
  - taken_cnt increments by 1 on every taken branch.
  - Saturates at 16'hFFFF (no wrap).
  - Cleared only by rst.
- Undefined:
  - Counter logic is not built; taken_cnt is tied to 16'h0000.
  - The port remains present so the interface is identical in both builds.

Test Plan:
- Reset, then sequential stepping: rst=1 for 2 cycles, then en=1, br_valid=0 for 3 cycles -> pc 0,4,8,12; taken=0; halted=0.
- Condition sweep: at pc=8, target=8'h40, run all 8 codes with values 0x00, 0x01, 0x80, 0x7F.
  - Taken exactly when the decode table holds, e.g. cond 011 taken for 0x00 and 0x80 but not 0x01.
  - cond 111 taken only for 0x01 and 0x7F.
  - Taken -> pc=0x40; not taken -> pc=0x0C.
- Wrap-around: PC_W=8, STEP=4, pc=8'hFC, en=1, br_valid=0 -> pc=8'h00, no other effect.
- Halt/resume:
  - At pc=0x10, halt_req=1 with cond=100, target=0x80 -> pc=0x80, taken=1, halted=1.
  - Next 5 cycles: pc stays 0x80 despite br_valid=1.
  - resume=1 -> halted=0, pc 0x80; next edge pc=0x84.
- Reset mid-operation and en gating:
  - en=0 for 3 cycles -> pc frozen.
  - rst=1 while HALTED at pc=0x80 -> pc=0, halted=0, taken_cnt=0 on the next edge.
- Stats (CONDITIONAL_BRANCH_STATS_EN defined): 5 taken and 3 not-taken branches -> taken_cnt=5; force 65540 taken -> taken_cnt=16'hFFFF. With the macro undefined, taken_cnt=0 throughout.
